// File: rtl/core_if_fetch_q.sv
// core_if_fetch_q: instruction-fetch front end. It issues sequential PCs to the
// I-cache over a valid/ready handshake and queues the returned instructions for decode.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   redirect_val/redirect_addr : taken branch or jump; flush and load a new PC
//   pc_stop                    : freeze request issue; the queue still drains
//   ic_req_val/addr/rdy        : cache request handshake
//   ic_rsp_val/data            : in-order cache responses
//   if_val/if_pc/if_pc_4/if_instr, dec_rdy : queue head handed to decode
module core_if_fetch_q #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PC_START = 32'h0000_0200,
  parameter int FQ_DEPTH = 4,
  parameter int CNT_W = $clog2(FQ_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_val,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            pc_stop,
  output logic            ic_req_val,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_req_rdy,
  input  logic            ic_rsp_val,
  input  logic [XLEN-1:0] ic_rsp_data,
  output logic            if_val,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4,
  output logic [XLEN-1:0] if_instr,
  input  logic            dec_rdy
);
  localparam int AW = $clog2(FQ_DEPTH);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] q_pc [FQ_DEPTH];
  logic [XLEN-1:0] q_pc_4 [FQ_DEPTH];
  logic [XLEN-1:0] q_instr [FQ_DEPTH];
  logic [XLEN-1:0] af [FQ_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, af_rd, af_wr;
  logic [CNT_W-1:0] count, outst, drop;
  logic req_fire, push, pop, stale;
  assign stale = drop != '0;
  // Credit rule: a request goes out only while a queue slot is reserved for its response.
  assign ic_req_val = rst_n & ~redirect_val & ~pc_stop &
                      (({1'b0, count} + {1'b0, outst}) < (CNT_W + 1)'(FQ_DEPTH));
  assign ic_req_addr = pc;
  assign req_fire = ic_req_val & ic_req_rdy;
  assign push = ic_rsp_val & ~stale;
  assign if_val = rst_n & (count != '0);
  assign pop = if_val & dec_rdy;
  assign if_pc = q_pc[rd_ptr];
  assign if_pc_4 = q_pc_4[rd_ptr];
  assign if_instr = q_instr[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= PC_START;
      rd_ptr <= '0;
      wr_ptr <= '0;
      af_rd <= '0;
      af_wr <= '0;
      count <= '0;
      outst <= '0;
      drop <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i] <= '0;
        q_pc_4[i] <= '0;
        q_instr[i] <= '0;
        af[i] <= '0;
      end
    end else if (redirect_val) begin
      pc <= {redirect_addr[XLEN-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      af_rd <= '0;
      af_wr <= '0;
      count <= '0;
      outst <= outst - CNT_W'(ic_rsp_val);
      // Every request still in flight is now stale, including ones already marked
      // stale by an earlier redirect, so drop tracks outst exactly and never exceeds it.
      drop <= outst - CNT_W'(ic_rsp_val);
    end else begin
      if (req_fire) begin
        pc <= pc + XLEN'(4);
        af[af_wr] <= pc;
        af_wr <= af_wr + 1'b1;
      end
      if (push) begin
        q_pc[wr_ptr] <= af[af_rd];
        q_pc_4[wr_ptr] <= af[af_rd] + XLEN'(4);
        q_instr[wr_ptr] <= ic_rsp_data;
        wr_ptr <= wr_ptr + 1'b1;
        af_rd <= af_rd + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ic_rsp_val && stale) drop <= drop - 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      outst <= outst + CNT_W'(req_fire) - CNT_W'(ic_rsp_val);
    end
  end
endmodule
